// File: rtl/pipelined_mux_tree_if.sv
// Bus interface for pipelined_mux_tree.
// Carries the channel inputs, select and request controls toward the tree, and the
// registered result (data, valid, producing channel, end-of-sweep flag) back out.
// When MUXTREE_PARITY_EN is defined it also carries f_par and the sticky par_err flag.
//   master : drives w, s, in_valid, scan_mode; observes the results
//   slave  : the mux tree itself
interface pipelined_mux_tree_if #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned LEVELS = 2
);
  localparam int unsigned SEL_W = 2 * LEVELS;
  localparam int unsigned N     = 1 << SEL_W;

  logic [N*DATA_W-1:0] w;
  logic [SEL_W-1:0]    s;
  logic                in_valid;
  logic                scan_mode;
  logic [DATA_W-1:0]   f;
  logic                out_valid;
  logic [SEL_W-1:0]    out_sel;
  logic                out_last;
`ifdef MUXTREE_PARITY_EN
  logic                f_par;
  logic                par_err;

  modport master (
    output w, s, in_valid, scan_mode,
    input  f, out_valid, out_sel, out_last, f_par, par_err
  );

  modport slave (
    input  w, s, in_valid, scan_mode,
    output f, out_valid, out_sel, out_last, f_par, par_err
  );
`else
  modport master (
    output w, s, in_valid, scan_mode,
    input  f, out_valid, out_sel, out_last
  );

  modport slave (
    input  w, s, in_valid, scan_mode,
    output f, out_valid, out_sel, out_last
  );
`endif
endinterface

// File: rtl/pipelined_mux_tree.sv
// Pipelined N:1 mux tree (N = 4^LEVELS) built from registered 4:1 levels.
// Level j picks among groups of four using select digit esel[2j-1:2j-2]; every level
// carries valid, the full select and an end-of-sweep tag alongside the data.
// A scan counter can replace the external select to sweep all channels in order.
// Optional feature macro: MUXTREE_PARITY_EN (adds f_par and sticky par_err).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : pipelined_mux_tree_if.slave (w, s, in_valid, scan_mode -> f, out_valid,
//          out_sel, out_last [, f_par, par_err])
module pipelined_mux_tree #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned LEVELS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_mux_tree_if.slave  bus
);

  localparam int unsigned SEL_W = 2 * LEVELS;
  localparam int unsigned N     = 1 << SEL_W;

  logic [SEL_W-1:0] scan_cnt;
  logic [SEL_W-1:0] esel;

  // Scan counter: advances per scan request, wraps naturally at N, parked at 0 outside scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (!bus.scan_mode) begin
      scan_cnt <= '0;
    end else if (bus.in_valid) begin
      scan_cnt <= scan_cnt + SEL_W'(1);
    end
  end

  assign esel = bus.scan_mode ? scan_cnt : bus.s;

  // Level 0 is the unregistered source; levels 1..LEVELS are the pipeline registers.
  for (genvar j = 0; j <= LEVELS; j++) begin : g_lvl
    localparam int unsigned CNT = N >> (2 * j);

    logic [CNT*DATA_W-1:0] data;
    logic                  valid;
    logic [SEL_W-1:0]      sel;
    logic                  last;
`ifdef MUXTREE_PARITY_EN
    logic                  ref_par;
`endif

    if (j == 0) begin : g_src
      assign data  = bus.w;
      assign valid = bus.in_valid;
      assign sel   = esel;
      // End-of-sweep tag: only scan samples of channel N-1 qualify.
      assign last  = bus.scan_mode & (&esel);
`ifdef MUXTREE_PARITY_EN
      // Reference parity of the channel actually requested, checked at the output.
      assign ref_par = ^(bus.w[int'(esel)*DATA_W +: DATA_W]);
`endif
    end else begin : g_stg
      logic [CNT*DATA_W-1:0] nxt;
      logic [1:0]            dig;

      assign dig = g_lvl[j-1].sel[2*(j-1) +: 2];

      // One 4:1 cell per output group of this level.
      always_comb begin
        nxt = '0;
        for (int g = 0; g < int'(CNT); g++) begin
          case (dig)
            2'd0:    nxt[g*DATA_W +: DATA_W] = g_lvl[j-1].data[(4*g+0)*DATA_W +: DATA_W];
            2'd1:    nxt[g*DATA_W +: DATA_W] = g_lvl[j-1].data[(4*g+1)*DATA_W +: DATA_W];
            2'd2:    nxt[g*DATA_W +: DATA_W] = g_lvl[j-1].data[(4*g+2)*DATA_W +: DATA_W];
            default: nxt[g*DATA_W +: DATA_W] = g_lvl[j-1].data[(4*g+3)*DATA_W +: DATA_W];
          endcase
        end
      end

      // Valid/last follow upstream every cycle; payload only moves with a valid sample.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid <= 1'b0;
          last  <= 1'b0;
          data  <= '0;
          sel   <= '0;
        end else begin
          valid <= g_lvl[j-1].valid;
          last  <= g_lvl[j-1].valid & g_lvl[j-1].last;
          if (g_lvl[j-1].valid) begin
            data <= nxt;
            sel  <= g_lvl[j-1].sel;
          end
        end
      end

`ifdef MUXTREE_PARITY_EN
      always_ff @(posedge clk) begin
        if (rst) begin
          ref_par <= 1'b0;
        end else if (g_lvl[j-1].valid) begin
          ref_par <= g_lvl[j-1].ref_par;
        end
      end

      if (j == LEVELS) begin : g_par
        logic f_par_q;
        logic par_err_q;

        // f_par is aligned with f; par_err latches any mismatch seen on a valid output.
        always_ff @(posedge clk) begin
          if (rst) begin
            f_par_q   <= 1'b0;
            par_err_q <= 1'b0;
          end else begin
            if (g_lvl[j-1].valid) begin
              f_par_q <= ^nxt;
            end
            if (valid && (ref_par != f_par_q)) begin
              par_err_q <= 1'b1;
            end
          end
        end

        assign bus.f_par   = f_par_q;
        assign bus.par_err = par_err_q;
      end
`endif
    end
  end

  assign bus.f         = g_lvl[LEVELS].data;
  assign bus.out_valid = g_lvl[LEVELS].valid;
  assign bus.out_sel   = g_lvl[LEVELS].sel;
  assign bus.out_last  = g_lvl[LEVELS].last;

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Self-checking bench for pipelined_mux_tree: a 16-channel 1-bit instance driven from
// vector tables plus hand-written sequences, and a 64-channel 8-bit instance.
module tb_pipelined_mux_tree;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_mux_tree_if #(.DATA_W(1), .LEVELS(2)) b16 ();
  pipelined_mux_tree_if #(.DATA_W(8), .LEVELS(3)) b64 ();

  pipelined_mux_tree #(.DATA_W(1), .LEVELS(2)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  pipelined_mux_tree #(.DATA_W(8), .LEVELS(3)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64)
  );

  typedef struct {
    logic       in_valid;
    logic       scan_mode;
    logic [3:0] s;
    logic       exp_valid;
    logic       exp_f;
    logic [3:0] exp_sel;
    logic       exp_last;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   last_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply table entries [first, first+count) one per cycle and check after each edge.
  task automatic run_tbl(input int first, input int count, input string tag);
    for (int i = first; i < first + count; i++) begin
      b16.in_valid  = tbl[i].in_valid;
      b16.scan_mode = tbl[i].scan_mode;
      b16.s         = tbl[i].s;
      tick();
      if (b16.out_last === 1'b1) last_cnt++;
      chk($sformatf("%s[%0d].out_valid", tag, i - first), 64'(b16.out_valid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("%s[%0d].f", tag, i - first), 64'(b16.f), 64'(tbl[i].exp_f));
        chk($sformatf("%s[%0d].out_sel", tag, i - first), 64'(b16.out_sel), 64'(tbl[i].exp_sel));
      end
      chk($sformatf("%s[%0d].out_last", tag, i - first), 64'(b16.out_last), 64'(tbl[i].exp_last));
    end
  endtask

  initial begin
    logic fl [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec_t v;

    // Manual sweep of w=16'hA5C3: requests s=0..15, outputs two edges later.
    for (int i = 0; i < 18; i++) begin
      v.in_valid  = (i < 16);
      v.scan_mode = 1'b0;
      v.s         = 4'(i);
      v.exp_valid = (i >= 1) && (i <= 16);
      v.exp_sel   = 4'(i - 1);
      v.exp_f     = v.exp_valid ? fl[i-1] : 1'b0;
      v.exp_last  = 1'b0;
      tbl.push_back(v);
    end
    // Scan sweep of w=16'h0001 for 20 requests; s is parked at 15 and must be ignored.
    for (int i = 0; i < 22; i++) begin
      v.in_valid  = (i < 20);
      v.scan_mode = (i < 20);
      v.s         = 4'hF;
      v.exp_valid = (i >= 1) && (i <= 20);
      v.exp_sel   = 4'((i - 1) % 16);
      v.exp_f     = v.exp_valid && (v.exp_sel == 4'd0);
      v.exp_last  = v.exp_valid && (v.exp_sel == 4'd15);
      tbl.push_back(v);
    end

    rst = 1'b1;
    b16.w = '0; b16.s = '0; b16.in_valid = 1'b0; b16.scan_mode = 1'b0;
    b64.w = '0; b64.s = '0; b64.in_valid = 1'b0; b64.scan_mode = 1'b0;
    tick();
    tick();
    chk("rst.f", 64'(b16.f), 64'd0);
    chk("rst.out_valid", 64'(b16.out_valid), 64'd0);
    chk("rst.out_sel", 64'(b16.out_sel), 64'd0);
    chk("rst.out_last", 64'(b16.out_last), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle[%0d].out_valid", i), 64'(b16.out_valid), 64'd0);
      chk($sformatf("idle[%0d].f", i), 64'(b16.f), 64'd0);
    end

    b16.w = 16'hA5C3;
    last_cnt = 0;
    run_tbl(0, 18, "manual");
    chk("manual.last_pulses", 64'(last_cnt), 64'd0);

    b16.w = 16'h0001;
    last_cnt = 0;
    run_tbl(18, 22, "scan");
    chk("scan.last_pulses", 64'(last_cnt), 64'd1);

    // Single gapped request; outputs must then hold while inputs wander.
    b16.scan_mode = 1'b0;
    b16.w = 16'h0200;
    b16.s = 4'd9;
    b16.in_valid = 1'b1;
    tick();
    chk("gap.stage1.out_valid", 64'(b16.out_valid), 64'd0);
    b16.in_valid = 1'b0;
    b16.w = 16'h0000;
    b16.s = 4'd3;
    tick();
    chk("gap.out_valid", 64'(b16.out_valid), 64'd1);
    chk("gap.f", 64'(b16.f), 64'd1);
    chk("gap.out_sel", 64'(b16.out_sel), 64'd9);
    for (int i = 0; i < 4; i++) begin
      b16.w = 16'(16'h1111 << i);
      b16.s = 4'(i + 1);
      tick();
      chk($sformatf("hold[%0d].out_valid", i), 64'(b16.out_valid), 64'd0);
      chk($sformatf("hold[%0d].f", i), 64'(b16.f), 64'd1);
      chk($sformatf("hold[%0d].out_sel", i), 64'(b16.out_sel), 64'd9);
    end

    // Two scan requests in flight, then reset while a third request is presented.
    b16.w = 16'h0001;
    b16.scan_mode = 1'b1;
    b16.in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst.out_valid", 64'(b16.out_valid), 64'd0);
    chk("midrst.f", 64'(b16.f), 64'd0);
    chk("midrst.out_sel", 64'(b16.out_sel), 64'd0);
    rst = 1'b0;
    b16.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("postrst[%0d].out_valid", i), 64'(b16.out_valid), 64'd0);
    end
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    tick();
    chk("restart.out_valid", 64'(b16.out_valid), 64'd1);
    chk("restart.out_sel", 64'(b16.out_sel), 64'd0);
    chk("restart.f", 64'(b16.f), 64'd1);
    b16.scan_mode = 1'b0;

    // 64-channel, 8-bit instance: channel k carries k, three-level latency.
    for (int k = 0; k < 64; k++) b64.w[k*8 +: 8] = 8'(k);
    b64.s = 6'd37;
    b64.in_valid = 1'b1;
    tick();
    b64.in_valid = 1'b0;
    chk("w64.lat1.out_valid", 64'(b64.out_valid), 64'd0);
    tick();
    chk("w64.lat2.out_valid", 64'(b64.out_valid), 64'd0);
    tick();
    chk("w64.out_valid", 64'(b64.out_valid), 64'd1);
    chk("w64.f", 64'(b64.f), 64'd37);
    chk("w64.out_sel", 64'(b64.out_sel), 64'd37);
    chk("w64.out_last", 64'(b64.out_last), 64'd0);
`ifdef MUXTREE_PARITY_EN
    chk("w64.f_par", 64'(b64.f_par), 64'd1);
    tick();
    chk("w64.par_err", 64'(b64.par_err), 64'd0);
    chk("w16.par_err", 64'(b16.par_err), 64'd0);
`endif
    tick();
    chk("w64.after.out_valid", 64'(b64.out_valid), 64'd0);
    chk("w64.after.f", 64'(b64.f), 64'd37);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_mux_tree.md
Name: pipelined_mux_tree

Overview:
- Parametrised, registered successor to the 16:1 combinational mux built from 4:1 stages.
- Selects one of N = 4^LEVELS channels, each DATA_W bits wide, through a tree of 4:1 levels with one register per level.
- Valid flag and select tag travel down the pipeline alongside the data.
- Built-in scan mode sweeps all channels in order, for sampling/monitor paths in lab designs.

Parameters:
- DATA_W, 1, width of each channel in bits (>=1).
- LEVELS, 2, number of 4:1 tree levels; channel count N = 4^LEVELS (default 16); LEVELS >= 1.
- Derived localparam: N = 4^LEVELS, SEL_W = 2*LEVELS.

Ports:
- clk  in  1  rising-edge clock, sole clock.
- rst  in  1  synchronous active-high reset.
- w  in  N*DATA_W  flattened channel inputs; channel k = w[k*DATA_W +: DATA_W].
- s  in  SEL_W  channel select (used when scan_mode=0).
- in_valid  in  1  sample request; w and s are captured this cycle.
- scan_mode  in  1  1 = use internal scan counter as select; 0 = use s.
- f  out  DATA_W  selected channel data.
- out_valid  out  1  f/out_sel valid this cycle.
- out_sel  out  SEL_W  channel index that produced f.
- out_last  out  1  scan-mode sample of channel N-1 (end of sweep).

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. All state changes occur on the rising edge of clk.
- Reset values: f=0, out_valid=0, out_sel=0, out_last=0, scan counter=0, all internal stage valids=0.
- Reset mid-operation: all in-flight samples are discarded. No out_valid is asserted after rst deasserts until a new in_valid propagates.
- Effective select: esel = scan_mode ? scan_cnt : s, sampled in the in_valid cycle.
- Level structure:
  - Level j (1..LEVELS) uses select digit esel[2j-1:2j-2].
  - Level 1 reduces N inputs to N/4; the final level produces one value.
  - Digit mapping per 4:1 group: 00->input0, 01->input1, 10->input2, 11->input3, matching the existing 4:1 cell.
- Pipeline registers:
  - Each level has data, valid and full-select registers.
  - Stage valid loads the upstream valid every cycle.
  - Stage data/select load only when the upstream valid=1; otherwise they hold.
- Latency: in_valid at edge t -> out_valid=1 at edge t+LEVELS. Throughput is one sample per cycle. There is no backpressure; the consumer must accept every out_valid.
- Output hold: f and out_sel keep the last valid value while out_valid=0.
- Scan counter:
  - Increments by 1 on each cycle with in_valid=1 and scan_mode=1.
  - Wraps N-1 -> 0.
  - Held at 0 whenever scan_mode=0.
  - A scan_mode 1->0 transition resets it to 0 on the next edge. In-flight scan samples still complete.
- out_last: asserted with out_valid when the emerging sample was taken in scan mode with index N-1. A scan-mode tag bit travels with each sample for this purpose. out_last is never asserted for manual-select samples, even if s = N-1.
- Simultaneous rst and in_valid: rst wins; the sample is dropped and the counter stays 0.
- Changes to s or w while in_valid=0 have no effect on outputs.

Optional Feature:
- Macro MUXTREE_PARITY_EN.
- When defined:
  - Adds output f_par (1 bit) = XOR of the f bits, registered with the final level and aligned with out_valid.
  - Adds output par_err, a sticky flag. It sets when any out_valid sample's recomputed parity of the data taken at level 1 mismatches f_par. It is cleared only by rst.
  - par_err is for fault-injection benches.
- When undefined: neither port nor logic exists; the behaviour of all other ports is identical.

Test Plan:
- Reset then idle (DATA_W=1, LEVELS=2): after rst, f=0, out_valid=0 for 10 cycles with in_valid=0.
- Manual select sweep: w=16'hA5C3, drive s=0..15 back-to-back with in_valid=1. out_valid rises 2 cycles after the first request; f follows w[s] (1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1); out_sel=0..15; out_last=0 throughout.
- Scan mode: scan_mode=1, in_valid=1 for 20 cycles, w=16'h0001. out_sel sequence 0..15,0..3; f=1 only at out_sel=0; out_last=1 exactly once per wrap, at out_sel=15.
- Gapped valid/hold: single request s=4'd9 with w[9]=1, then in_valid=0. One out_valid pulse 2 cycles later with f=1. f holds 1 while out_valid=0 even after w changes.
- Reset mid-flight: issue 2 requests, assert rst the following cycle. No out_valid after rst; the scan counter restarts at out_sel=0.
- Width/depth: DATA_W=8, LEVELS=3 (N=64), w[k]=k, s=37. f=8'd37, out_valid 3 cycles after in_valid. With MUXTREE_PARITY_EN, f_par=1 and par_err=0.
